// File: rtl/approx_dot_acc.sv
// Dot-product accumulator placed after the 8x8 approximate LUT multiplier.
// Operand pairs are registered onto the multiplier, and each product is added to the sum one cycle later.
module approx_dot_acc #(
  parameter int LEN   = 8,
  parameter int ACC_W = 24,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the sender holds its data stable while valid is high and ready is low.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mul_a;
  logic [7:0]       r_mul_b;
  logic             r_pipe_v;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [7:0]       r_out_count;
  logic             r_out_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic [8:0]       w_cnt_inc;
  logic             w_complete;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_add;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_ovf_nxt;
  logic             w_out_hs;

  assign w_in_ready = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign w_accept   = in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && out_ready;

  // A vector ends on in_last or when this pair brings the count up to LEN.
  assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
  assign w_complete = in_last || (w_cnt_inc == 9'(LEN));

  // One extra bit catches the carry-out used for the sticky overflow flag.
  assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, mul_p};
  assign w_carry   = w_sum_ext[ACC_W];
  assign w_acc_add = (w_carry && (SAT != 0)) ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
  assign w_acc_nxt = r_pipe_v ? w_acc_add : r_acc;
  assign w_ovf_nxt = r_ovf | (r_pipe_v & w_carry);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          w_state_nxt = w_complete ? S_DRAIN : S_ACCUM;
        end
      end
      S_DRAIN: w_state_nxt = S_OUT;
      S_OUT: begin
        if (w_out_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_pipe_v <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pipe_v <= w_accept;
      if (w_accept) begin
        r_mul_a <= in_a;
        r_mul_b <= in_b;
      end
    end
  end

  // Accumulator, pair counter and sticky flag clear only on the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_out_hs) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
      if (w_accept) begin
        r_cnt <= w_cnt_inc[7:0];
      end
    end
  end

  // DRAIN folds in the final product and publishes the result in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_acc_nxt;
      r_out_count <= r_cnt;
      r_out_ovf   <= w_ovf_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_approx_dot_acc.sv
// Bench for approx_dot_acc: four configurations share one driver and one expected-result queue.
module tb_approx_dot_acc;

  localparam int EW = 35;  // {idx[1:0], ovf, count[7:0], sum[23:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals (index = instance) ----------------
  logic        in_valid [4];
  logic        in_last  [4];
  logic [7:0]  in_a     [4];
  logic [7:0]  in_b     [4];
  logic        out_ready[4];
  logic        in_ready [4];
  logic        out_valid[4];
  logic        out_ovf  [4];
  logic [7:0]  mul_a    [4];
  logic [7:0]  mul_b    [4];
  logic [15:0] mul_p    [4];
  logic [7:0]  out_count[4];
  logic [23:0] out_sum  [4];
  logic [1:0]  dbg_state[4];
  logic [15:0] sum16_1, sum16_2;

  // Per-instance configuration used by the reference model.
  int p_len [4] = '{4, 8, 8, 1};
  int p_accw[4] = '{24, 16, 16, 24};
  int p_sat [4] = '{1, 1, 0, 1};

  // Exact multiplier model feeding every instance.
  for (genvar g = 0; g < 4; g++) begin : g_mul
    assign mul_p[g] = {8'd0, mul_a[g]} * {8'd0, mul_b[g]};
  end
  assign out_sum[1] = {8'd0, sum16_1};
  assign out_sum[2] = {8'd0, sum16_2};

  approx_dot_acc #(.LEN(4), .ACC_W(24), .SAT(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_last(in_last[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum[0]),
    .out_count(out_count[0]), .out_ovf(out_ovf[0]), .dbg_state(dbg_state[0]));

  approx_dot_acc #(.LEN(8), .ACC_W(16), .SAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_last(in_last[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(sum16_1),
    .out_count(out_count[1]), .out_ovf(out_ovf[1]), .dbg_state(dbg_state[1]));

  approx_dot_acc #(.LEN(8), .ACC_W(16), .SAT(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_last(in_last[2]),
    .mul_a(mul_a[2]), .mul_b(mul_b[2]), .mul_p(mul_p[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(sum16_2),
    .out_count(out_count[2]), .out_ovf(out_ovf[2]), .dbg_state(dbg_state[2]));

  approx_dot_acc #(.LEN(1), .ACC_W(24), .SAT(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_a(in_a[3]), .in_b(in_b[3]), .in_last(in_last[3]),
    .mul_a(mul_a[3]), .mul_b(mul_b[3]), .mul_p(mul_p[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_sum(out_sum[3]),
    .out_count(out_count[3]), .out_ovf(out_ovf[3]), .dbg_state(dbg_state[3]));

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [7:0] last_a[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result: true dot product, then clamp or wrap to the accumulator width.
  function automatic logic [EW-1:0] model(input int idx, input longint sum_true, input int n);
    longint lim;
    logic [23:0] s;
    logic o;
    lim = longint'(1) << p_accw[idx];
    o = (sum_true >= lim);
    if (!o)               s = 24'(sum_true);
    else if (p_sat[idx] != 0) s = 24'(lim - 1);
    else                  s = 24'(sum_true % lim);
    return {2'(idx), o, 8'(n), s};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_vec(input int idx, input int n, input logic [63:0] av,
                          input logic [63:0] bv, input bit use_last, input int gap);
    int t;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      in_valid[idx] = 1'b1;
      in_a[idx]     = av[8*j +: 8];
      in_b[idx]     = bv[8*j +: 8];
      in_last[idx]  = use_last && (j == n - 1);
      t = 0;
      while (!in_ready[idx] && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready[idx]) chk($sformatf("u%0d_in_ready_timeout", idx), 32'(in_ready[idx]), 1);
      @(posedge clk);
      last_a[idx] = av[8*j +: 8];
      if (gap > 0) begin
        @(negedge clk);
        in_valid[idx] = 1'b0;
        in_last[idx]  = 1'($urandom_range(0, 1));  // in_last without in_valid is ignored
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid[idx] = 1'b0;
    in_last[idx]  = 1'b0;
  endtask

  // Wait for a result, hold backpressure for `delay` cycles, then take it.
  task automatic recv(input int idx, input int delay);
    int t;
    logic [EW-1:0] e;
    t = 0;
    while (!out_valid[idx] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid[idx]) begin
      chk($sformatf("u%0d_out_valid_timeout", idx), 32'(out_valid[idx]), 1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk($sformatf("u%0d_exp_q_empty", idx), 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("u%0d_exp_idx", idx), 32'(e[34:33]), 32'(idx));
    chk($sformatf("u%0d_out_sum", idx), 32'(out_sum[idx]), 32'(e[23:0]));
    chk($sformatf("u%0d_out_count", idx), 32'(out_count[idx]), 32'(e[31:24]));
    chk($sformatf("u%0d_out_ovf", idx), 32'(out_ovf[idx]), 32'(e[32]));
    for (int d = 0; d < delay; d++) begin
      in_valid[idx] = 1'b1;
      in_a[idx]     = 8'hA5;
      in_b[idx]     = 8'h5A;
      @(negedge clk);
      chk($sformatf("u%0d_hold_valid", idx), 32'(out_valid[idx]), 1);
      chk($sformatf("u%0d_hold_sum", idx), 32'(out_sum[idx]), 32'(e[23:0]));
      chk($sformatf("u%0d_hold_count", idx), 32'(out_count[idx]), 32'(e[31:24]));
      chk($sformatf("u%0d_hold_in_ready", idx), 32'(in_ready[idx]), 0);
      chk($sformatf("u%0d_hold_no_accept", idx), 32'(mul_a[idx]), 32'(last_a[idx]));
    end
    out_ready[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[idx] = 1'b0;
    in_valid[idx]  = 1'b0;
    chk($sformatf("u%0d_valid_drop", idx), 32'(out_valid[idx]), 0);
    chk($sformatf("u%0d_ready_after_hs", idx), 32'(in_ready[idx]), 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          idx;
    int          n;
    logic [63:0] a;
    logic [63:0] b;
    bit          last;
    int          gap;
    int          delay;
    logic [23:0] sum;
    logic [7:0]  cnt;
    bit          ovf;
  } vec_t;

  function automatic vec_t mk(input int idx, input int n, input logic [63:0] a,
                              input logic [63:0] b, input bit last, input int gap,
                              input int delay, input logic [23:0] s, input logic [7:0] c,
                              input bit o);
    vec_t v;
    v.idx = idx; v.n = n; v.a = a; v.b = b; v.last = last; v.gap = gap;
    v.delay = delay; v.sum = s; v.cnt = c; v.ovf = o;
    return v;
  endfunction

  vec_t tbl[12];

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready[0]), 1);
    chk({tag, "_out_valid"}, 32'(out_valid[0]), 0);
    chk({tag, "_out_sum"}, 32'(out_sum[0]), 0);
    chk({tag, "_out_count"}, 32'(out_count[0]), 0);
    chk({tag, "_out_ovf"}, 32'(out_ovf[0]), 0);
    chk({tag, "_mul_a"}, 32'(mul_a[0]), 0);
    chk({tag, "_mul_b"}, 32'(mul_b[0]), 0);
  endtask

  logic [63:0] ca, cb;

  initial begin
    ca = 64'({8'd7, 8'd5, 8'd3, 8'd1});
    cb = 64'({8'd8, 8'd6, 8'd4, 8'd2});
    tbl[0]  = mk(0, 4, ca, cb, 0, 0, 0, 100, 4, 0);
    tbl[1]  = mk(0, 4, ca, cb, 0, 2, 0, 100, 4, 0);                 // bubbles
    tbl[2]  = mk(0, 4, ca, cb, 0, 0, 5, 100, 4, 0);                 // backpressure
    tbl[3]  = mk(0, 1, 64'd2, 64'd2, 1, 0, 0, 4, 1, 0);             // restarts from zero
    tbl[4]  = mk(1, 2, 64'({8'd20, 8'd10}), 64'({8'd20, 8'd10}), 1, 0, 2, 500, 2, 0);
    tbl[5]  = mk(1, 2, 64'hFFFF, 64'hFFFF, 1, 0, 0, 65535, 2, 1);    // clamp
    tbl[6]  = mk(2, 2, 64'hFFFF, 64'hFFFF, 1, 0, 0, 64514, 2, 1);    // wrap
    tbl[7]  = mk(1, 8, {8{8'd100}}, {8{8'd100}}, 0, 0, 0, 65535, 8, 1);
    tbl[8]  = mk(2, 8, {8{8'd100}}, {8{8'd100}}, 0, 0, 0, 14464, 8, 1);
    tbl[9]  = mk(3, 1, 64'd9, 64'd7, 0, 0, 0, 63, 1, 0);            // LEN=1
    tbl[10] = mk(3, 1, 64'd200, 64'd3, 1, 0, 1, 600, 1, 0);
    tbl[11] = mk(0, 4, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, 1, 0, 260100, 4, 0);

    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; in_last[k] = 1'b0; in_a[k] = '0; in_b[k] = '0;
      out_ready[k] = 1'b0; last_a[k] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    reset_checks("reset");
    chk("reset_state", 32'(dbg_state[0]), 0);
    rst = 1'b0;

    // Back-to-back with out_ready already high: exact output timing.
    out_ready[0] = 1'b1;
    send_vec(0, 4, ca, cb, 0, 0);
    chk("c1_valid_in_drain", 32'(out_valid[0]), 0);
    chk("c1_ready_in_drain", 32'(in_ready[0]), 0);
    @(negedge clk);
    chk("c1_valid_rise", 32'(out_valid[0]), 1);
    chk("c1_sum", 32'(out_sum[0]), 100);
    chk("c1_count", 32'(out_count[0]), 4);
    chk("c1_ovf", 32'(out_ovf[0]), 0);
    @(negedge clk);
    chk("c1_valid_one_cycle", 32'(out_valid[0]), 0);
    chk("c1_ready_back", 32'(in_ready[0]), 1);
    out_ready[0] = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({2'(tbl[i].idx), tbl[i].ovf, tbl[i].cnt, tbl[i].sum});
      send_vec(tbl[i].idx, tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].gap);
      recv(tbl[i].idx, tbl[i].delay);
    end

    // Reset in the middle of a vector discards the partial sum.
    send_vec(0, 2, ca, cb, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 reset_checks("midrst");
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({2'd0, 1'b0, 8'd2, 24'd26});
    send_vec(0, 2, 64'({8'd4, 8'd2}), 64'({8'd5, 8'd3}), 1, 0);
    recv(0, 0);

    // Randomized vectors against the reference model
    for (int r = 0; r < 40; r++) begin
      int idx, n, len;
      bit use_last, big;
      logic [63:0] av, bv;
      longint s;
      idx = $urandom_range(0, 3);
      len = p_len[idx];
      n   = (idx == 3) ? 1 : $urandom_range(1, len);
      use_last = (n < len) ? 1'b1 : 1'($urandom_range(0, 1));
      big = 1'($urandom_range(0, 1));
      av = '0; bv = '0; s = 0;
      for (int j = 0; j < n; j++) begin
        av[8*j +: 8] = big ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
        bv[8*j +: 8] = big ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
        s += longint'(av[8*j +: 8]) * longint'(bv[8*j +: 8]);
      end
      exp_q.push_back(model(idx, s, n));
      send_vec(idx, n, av, bv, use_last, $urandom_range(0, 2));
      recv(idx, $urandom_range(0, 3));
    end

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
